data_rx_rgb555_multi: RTL and testbench

Parametrised byte-stream pixel receiver for the LED panel datapath. Accepts the AL422 FIFO read stream one byte per qualified clock, assembles little-endian RGB555 pixels for NUM_CH parallel scan channels, and compares each colour component against the current PWM threshold to drive the panel RGB lines. It also tracks column and line position and issues the LED shift clock, the PWM-counter advance strobe and the AL422 read-reset strobe.

---
 rtl/data_rx_rgb555_multi.sv | 136 +++++++++++++
 tb/tb_data_rx_rgb555_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_rx_rgb555_multi.sv
// Byte-stream RGB555 receiver: assembles NUM_CH pixels per shift group, PWM-compares them, tracks column/line.
// Optional feature macro: DATA_RX_BLANK_EN adds the blank input that zeroes rgb at a commit.
module data_rx_rgb555_multi #(
  parameter int NUM_CH   = 2,
  parameter int PWM_BITS = 5,
  parameter int COLS     = 64,
  parameter int LINES    = 16
) (
  input  logic                  in_clk,
  input  logic                  in_nrst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic [PWM_BITS-1:0]   pwm_value,
`ifdef DATA_RX_BLANK_EN
  input  logic                  blank,
`endif
  output logic                  led_clk,
  output logic                  pwm_cntr_strobe,
  output logic                  alrst_strobe,
  output logic [3*NUM_CH-1:0]   rgb
);

  localparam int PW = $clog2(2 * NUM_CH);
  localparam int CW = $clog2(COLS);
  localparam int LW = $clog2(LINES);

  localparam logic [PW-1:0] P_LAST    = PW'(2 * NUM_CH - 1);
  localparam logic [PW-1:0] P_ONE     = PW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [CW-1:0] C_ONE     = CW'(1);
  localparam logic [LW-1:0] LINE_LAST = LW'(LINES - 1);
  localparam logic [LW-1:0] L_ONE     = LW'(1);

  // Strict compare of each component's top PWM_BITS bits against the threshold; result is {B,G,R}.
  function automatic logic [2:0] rgb_cmp(input logic [14:0] word, input logic [PWM_BITS-1:0] thr);
    logic [4:0] r, g, b;
    r = word[4:0];
    g = word[9:5];
    b = word[14:10];
    rgb_cmp = {(b[4 -: PWM_BITS] > thr), (g[4 -: PWM_BITS] > thr), (r[4 -: PWM_BITS] > thr)};
  endfunction

  logic [PW-1:0]       p_r;
  logic [CW-1:0]       col_r;
  logic [LW-1:0]       line_r;
  logic [7:0]          low_r;
  logic [2:0]          staging_r [NUM_CH];
  logic [3*NUM_CH-1:0] rgb_r;
  logic                led_clk_r;
  logic                pwm_strobe_r;
  logic                alrst_r;

  logic [14:0]         word_s;
  logic [2:0]          cmp_s;
  logic [PW-1:0]       ch_s;
  logic                commit_s;
  logic [3*NUM_CH-1:0] grp_s;
  logic [3*NUM_CH-1:0] rgb_next_s;

  // Pixel compare and next group value; the last channel is taken straight from the current compare.
  always_comb begin
    word_s   = {in_data[6:0], low_r};
    cmp_s    = rgb_cmp(word_s, pwm_value);
    ch_s     = p_r >> 1;
    commit_s = in_valid && (p_r == P_LAST);
    grp_s    = '0;
    for (int k = 0; k < NUM_CH - 1; k++) begin
      grp_s[3*k +: 3] = staging_r[k];
    end
    grp_s[3*(NUM_CH-1) +: 3] = cmp_s;
`ifdef DATA_RX_BLANK_EN
    rgb_next_s = blank ? '0 : grp_s;
`else
    rgb_next_s = grp_s;
`endif
  end

  // Byte phase, staging, group commit and column/line bookkeeping; strobes self-clear every cycle.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      p_r          <= '0;
      col_r        <= '0;
      line_r       <= '0;
      low_r        <= 8'h00;
      rgb_r        <= '0;
      led_clk_r    <= 1'b0;
      pwm_strobe_r <= 1'b0;
      alrst_r      <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        staging_r[k] <= 3'b000;
      end
    end else begin
      led_clk_r    <= 1'b0;
      pwm_strobe_r <= 1'b0;
      alrst_r      <= 1'b0;
      if (in_valid) begin
        if (p_r == P_LAST) begin
          p_r <= '0;
        end else begin
          p_r <= p_r + P_ONE;
        end
        if (p_r[0] == 1'b0) begin
          low_r <= in_data;
        end else begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (ch_s == PW'(k)) begin
              staging_r[k] <= cmp_s;
            end
          end
        end
        if (commit_s) begin
          rgb_r     <= rgb_next_s;
          led_clk_r <= 1'b1;
          if (col_r == COL_LAST) begin
            col_r        <= '0;
            pwm_strobe_r <= 1'b1;
            if (line_r == LINE_LAST) begin
              line_r  <= '0;
              alrst_r <= 1'b1;
            end else begin
              line_r <= line_r + L_ONE;
            end
          end else begin
            col_r <= col_r + C_ONE;
          end
        end
      end
    end
  end

  assign led_clk         = led_clk_r;
  assign pwm_cntr_strobe = pwm_strobe_r;
  assign alrst_strobe    = alrst_r;
  assign rgb             = rgb_r;

endmodule

// File: tb/tb_data_rx_rgb555_multi.sv
// Self-checking bench for data_rx_rgb555_multi (NUM_CH=2, COLS=4, LINES=2) against an arithmetic pixel/group model.
module tb_data_rx_rgb555_multi;

  localparam int NUM_CH   = 2;
  localparam int PWM_BITS = 5;
  localparam int COLS     = 4;
  localparam int LINES    = 2;
`ifdef DATA_RX_BLANK_EN
  localparam bit HAS_BLANK = 1'b1;
`else
  localparam bit HAS_BLANK = 1'b0;
`endif

  logic                in_clk = 1'b0;
  logic                in_nrst;
  logic [7:0]          in_data;
  logic                in_valid;
  logic [PWM_BITS-1:0] pwm_value;
  logic                blank;
  logic                led_clk;
  logic                pwm_cntr_strobe;
  logic                alrst_strobe;
  logic [3*NUM_CH-1:0] rgb;

  data_rx_rgb555_multi #(.NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .COLS(COLS), .LINES(LINES)) dut (
    .in_clk          (in_clk),
    .in_nrst         (in_nrst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .pwm_value       (pwm_value),
`ifdef DATA_RX_BLANK_EN
    .blank           (blank),
`endif
    .led_clk         (led_clk),
    .pwm_cntr_strobe (pwm_cntr_strobe),
    .alrst_strobe    (alrst_strobe),
    .rgb             (rgb)
  );

  always #5 in_clk = ~in_clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                  nb;
  int                  lo;
  logic [2:0]          pix [NUM_CH];
  int                  groups;
  logic [3*NUM_CH-1:0] exp_rgb;
  logic                exp_led, exp_pstb, exp_astb;

  function automatic logic [2:0] ref_pix(input int w, input int thr);
    int sh, r, g, b;
    sh = 1 << (5 - PWM_BITS);
    r  = w % 32;
    g  = (w / 32) % 32;
    b  = (w / 1024) % 32;
    return {((b / sh) > thr), ((g / sh) > thr), ((r / sh) > thr)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    nb = 0; lo = 0; groups = 0;
    exp_rgb = '0; exp_led = 1'b0; exp_pstb = 1'b0; exp_astb = 1'b0;
    for (int k = 0; k < NUM_CH; k++) pix[k] = 3'b000;
  endtask

  task automatic check_outputs();
    chk("led_clk", 32'(led_clk), 32'(exp_led));
    chk("pwm_cntr_strobe", 32'(pwm_cntr_strobe), 32'(exp_pstb));
    chk("alrst_strobe", 32'(alrst_strobe), 32'(exp_astb));
    chk("rgb", 32'(rgb), 32'(exp_rgb));
  endtask

  // One clock: drive inputs, advance the model, check outputs #1 after the edge.
  task automatic step(input bit v, input logic [7:0] d, input int thr, input bit bl);
    in_valid = v; in_data = d; pwm_value = thr[PWM_BITS-1:0]; blank = bl;
    exp_led = 1'b0; exp_pstb = 1'b0; exp_astb = 1'b0;
    if (v) begin
      if (nb % 2 == 0) lo = int'(d);
      else pix[nb / 2] = ref_pix(int'(d) * 256 + lo, thr);
      nb++;
      if (nb == 2 * NUM_CH) begin
        nb = 0;
        groups++;
        exp_led = 1'b1;
        for (int k = 0; k < NUM_CH; k++) exp_rgb[3*k +: 3] = pix[k];
        if (HAS_BLANK && bl) exp_rgb = '0;
        exp_pstb = (groups % COLS) == 0;
        exp_astb = (groups % (COLS * LINES)) == 0;
      end
    end
    @(posedge in_clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    in_nrst = 1'b0;
    #2;
    model_reset();
    check_outputs();
    repeat (2) @(posedge in_clk);
    #1;
    check_outputs();
    in_nrst = 1'b1;
  endtask

  task automatic group4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input int thr);
    step(1'b1, b0, thr, 1'b0);
    step(1'b1, b1, thr, 1'b0);
    step(1'b1, b2, thr, 1'b0);
    step(1'b1, b3, thr, 1'b0);
  endtask

  task automatic rand_group();
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      while ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), int'($urandom_range(0, 31)), 1'($urandom));
      step(1'b1, 8'($urandom), int'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    in_nrst = 1'b0; in_valid = 1'b0; in_data = 8'h00; pwm_value = '0; blank = 1'b0;
    model_reset();
    @(posedge in_clk);
    #1;
    do_reset();

    // Basic decode: ch0 red, ch1 green
    group4(8'h1F, 8'h00, 8'hE0, 8'h03, 0);
    chk("tp_basic", 32'(rgb), 32'h11);
    step(1'b1, 8'h00, 0, 1'b0);
    chk("led_single", 32'(led_clk), 32'h0);

    // Threshold edges (completes group opened above with pixel 0 = 0x??00)
    step(1'b1, 8'h00, 0, 1'b0);
    step(1'b1, 8'hFF, 30, 1'b0);
    step(1'b1, 8'h7F, 30, 1'b0);
    group4(8'hFF, 8'h7F, 8'hFF, 8'h7F, 30);
    chk("thr30", 32'(rgb), 32'h3F);
    group4(8'hFF, 8'h7F, 8'hFF, 8'h7F, 31);
    chk("thr31", 32'(rgb), 32'h00);

    // Gap of 5 idle cycles between bytes 2 and 3
    step(1'b1, 8'h1F, 0, 1'b0);
    step(1'b1, 8'h00, 0, 1'b0);
    repeat (5) step(1'b0, 8'hA5, 0, 1'b0);
    step(1'b1, 8'hE0, 0, 1'b0);
    step(1'b1, 8'h03, 0, 1'b0);
    chk("gap_rgb", 32'(rgb), 32'h11);

    // Random traffic across several lines and frames
    for (int g = 0; g < 24; g++) rand_group();

    // Reset mid-group after byte 1
    group4(8'hFF, 8'h7F, 8'hFF, 8'h7F, 0);
    step(1'b1, 8'h55, 0, 1'b0);
    do_reset();
    group4(8'h1F, 8'h00, 8'hE0, 8'h03, 0);
    chk("post_reset", 32'(rgb), 32'h11);
    for (int g = 0; g < 8; g++) rand_group();

`ifdef DATA_RX_BLANK_EN
    step(1'b1, 8'hFF, 0, 1'b1);
    step(1'b1, 8'h7F, 0, 1'b1);
    step(1'b1, 8'hFF, 0, 1'b1);
    step(1'b1, 8'h7F, 0, 1'b1);
    chk("blank_on", 32'(rgb), 32'h00);
    step(1'b1, 8'hFF, 0, 1'b1);
    step(1'b1, 8'h7F, 0, 1'b1);
    step(1'b1, 8'hFF, 0, 1'b1);
    step(1'b1, 8'h7F, 0, 1'b0);
    chk("blank_off", 32'(rgb), 32'h3F);
`endif

    repeat (3) step(1'b0, 8'h00, 0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
